// File: rtl/code_pulse_decoder_pkg.sv
// ---------------------------------------------------------------------------
// code_pulse_decoder_pkg
// Shared priority-code package: 3-bit line code and 8-bit one-hot line
// types, the decoder FSM state enum and the fixed code->line decode table.
// The existing priority encoder's bench uses decode_code() for round-trip
// checks, so the table here is the single source of truth.
// ---------------------------------------------------------------------------
package code_pulse_decoder_pkg;

   localparam int NUM_LINES = 8;

   typedef logic [2:0]           code_t;
   typedef logic [NUM_LINES-1:0] line_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      GAP    = 2'd2
   } state_t;

   // The code assignment is not binary for the low lines: 010 selects
   // line 3, 001 line 2 and 011 line 1. This mirrors the encoder.
   function automatic line_t decode_code(input code_t code);
      line_t line;
      line = '0;
      case (code)
         3'b111:  line = 8'h80;
         3'b110:  line = 8'h40;
         3'b101:  line = 8'h20;
         3'b100:  line = 8'h10;
         3'b010:  line = 8'h08;
         3'b001:  line = 8'h04;
         3'b011:  line = 8'h02;
         default: line = 8'h01;  // 3'b000
      endcase
      return line;
   endfunction

endpackage

// File: rtl/code_pulse_decoder_if.sv
// ---------------------------------------------------------------------------
// code_pulse_decoder_if
// Command-side bundle of the pulse decoder.
//   code_in    : 3-bit line code (master -> decoder)
//   code_valid : code_in valid (master -> decoder)
//   code_ready : decoder can accept a code (decoder -> master)
//   line_out   : one-hot strobe, zero when not strobing (decoder -> master)
//   busy       : decoder in ACTIVE or GAP (decoder -> master)
//   done       : one-cycle pulse at strobe end (decoder -> master)
// ---------------------------------------------------------------------------
interface code_pulse_decoder_if;
   import code_pulse_decoder_pkg::*;

   code_t code_in;
   logic  code_valid;
   logic  code_ready;
   line_t line_out;
   logic  busy;
   logic  done;

   modport master (
      output code_in, code_valid,
      input  code_ready, line_out, busy, done
   );

   modport slave (
      input  code_in, code_valid,
      output code_ready, line_out, busy, done
   );

endinterface

// File: rtl/code_pulse_decoder_onehot_lut.sv
// ---------------------------------------------------------------------------
// code_onehot_lut
// Purely combinational 3->8 table: maps a line code to its one-hot line.
//   code : 3-bit line code in
//   line : 8-bit one-hot line out (exactly one bit set for any code)
// ---------------------------------------------------------------------------
module code_onehot_lut
   import code_pulse_decoder_pkg::*;
(
   input  code_t code,
   output line_t line
);

   assign line = decode_code(code);

endmodule

// File: rtl/code_pulse_decoder.sv
// ---------------------------------------------------------------------------
// code_pulse_decoder
// Accepts a 3-bit line code over a valid/ready handshake and drives the
// matching one of eight lines as a PULSE_LEN-cycle strobe, followed by a
// GAP_LEN-cycle recovery gap before the next code is accepted.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : code_pulse_decoder_if.slave (code_in/code_valid/code_ready,
//          line_out, busy, done)
//
// Parameters:
//   PULSE_LEN : strobe length in cycles (1..255)
//   GAP_LEN   : idle cycles after a strobe (0..255)
//   CNT_W     : counter width, must hold max(PULSE_LEN, GAP_LEN)
//
// Build option:
//   DEC_ZERO_IDLE_EN : when defined, code 000 means "no request". It is
//   still accepted, but no strobe and no done are produced; the FSM goes
//   straight to GAP (or stays in IDLE when GAP_LEN is 0).
// ---------------------------------------------------------------------------
module code_pulse_decoder
   import code_pulse_decoder_pkg::*;
#(
   parameter int PULSE_LEN = 4,
   parameter int GAP_LEN   = 1,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   code_pulse_decoder_if.slave  bus
);

   // Counter reload values; the counter counts down to zero inclusive.
   localparam logic [CNT_W-1:0] PULSE_RELOAD = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_RELOAD   =
      (GAP_LEN == 0) ? '0 : CNT_W'(GAP_LEN - 1);

   state_t           state_q, state_d;
   code_t            code_q,  code_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   line_t            line_q,  line_d;
   logic             done_q,  done_d;

   line_t            line_dec;
   logic             accept;

   assign accept = bus.code_valid && bus.code_ready;

   // Captured-code path: on an accept the LUT sees the incoming code so
   // the strobe can be registered on the accept edge itself; afterwards it
   // sees the held code, which keeps line_out stable through ACTIVE.
   always_comb begin
      code_d = code_q;
      if ((state_q == IDLE) && accept) begin
         code_d = bus.code_in;
      end
   end

   code_onehot_lut u_lut (
      .code (code_d),
      .line (line_dec)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      line_d  = line_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            line_d = '0;
            if (accept) begin
`ifdef DEC_ZERO_IDLE_EN
               if (bus.code_in == 3'b000) begin
                  // "No request": complete the handshake, skip the strobe.
                  if (GAP_LEN == 0) begin
                     state_d = IDLE;
                  end else begin
                     state_d = GAP;
                     cnt_d   = GAP_RELOAD;
                  end
               end else
`endif
               begin
                  state_d = ACTIVE;
                  cnt_d   = PULSE_RELOAD;
                  line_d  = line_dec;
               end
            end
         end

         ACTIVE: begin
            if (cnt_q == '0) begin
               line_d = '0;
               done_d = 1'b1;
               if (GAP_LEN == 0) begin
                  state_d = IDLE;
               end else begin
                  state_d = GAP;
                  cnt_d   = GAP_RELOAD;
               end
            end else begin
               cnt_d  = cnt_q - 1'b1;
               line_d = line_dec;
            end
         end

         GAP: begin
            line_d = '0;
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            line_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         code_q  <= '0;
         cnt_q   <= '0;
         line_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
         line_q  <= line_d;
         done_q  <= done_d;
      end
   end

   // Ready is held low for the whole reset, not just until the next edge.
   assign bus.code_ready = (state_q == IDLE) && !rst;
   assign bus.line_out   = line_q;
   assign bus.done       = done_q;
   assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_code_pulse_decoder.sv
// ---------------------------------------------------------------------------
// tb_code_pulse_decoder
// Two decoder instances: dut_a with PULSE_LEN=4/GAP_LEN=1 and dut_b with
// PULSE_LEN=1/GAP_LEN=0. Expected strobes are queued at handshake time and
// compared when the strobe appears; width and done are checked at its end.
// Honours DEC_ZERO_IDLE_EN for the expectations of code 000.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_code_pulse_decoder;

`ifdef DEC_ZERO_IDLE_EN
   localparam bit ZERO_EN = 1'b1;
`else
   localparam bit ZERO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   code_pulse_decoder_if dif_a ();
   code_pulse_decoder_if dif_b ();

   code_pulse_decoder #(.PULSE_LEN(4), .GAP_LEN(1), .CNT_W(8)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (dif_a)
   );

   code_pulse_decoder #(.PULSE_LEN(1), .GAP_LEN(0), .CNT_W(8)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (dif_b)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_line(input logic [2:0] c);
      case (c)
         3'b111:  return 8'h80;
         3'b110:  return 8'h40;
         3'b101:  return 8'h20;
         3'b100:  return 8'h10;
         3'b010:  return 8'h08;
         3'b001:  return 8'h04;
         3'b011:  return 8'h02;
         default: return 8'h01;
      endcase
   endfunction

   // Scoreboard state, index 0 = dut_a, 1 = dut_b
   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];
   logic [7:0] prev_line [2];
   int         run_len   [2];
   int         acc_cnt   [2];
   int         acc_cyc   [2];
   int         plen      [2];

   initial begin
      plen[0] = 4;
      plen[1] = 1;
      for (int k = 0; k < 2; k++) begin
         prev_line[k] = '0;
         run_len[k]   = 0;
         acc_cnt[k]   = 0;
         acc_cyc[k]   = 0;
      end
   end

   task automatic mon(input int i);
      logic [7:0] ln;
      logic [7:0] e;
      logic       dn, rdy, vld;
      logic [2:0] cd;
      if (i == 0) begin
         ln = dif_a.line_out; dn = dif_a.done; rdy = dif_a.code_ready;
         vld = dif_a.code_valid; cd = dif_a.code_in;
      end else begin
         ln = dif_b.line_out; dn = dif_b.done; rdy = dif_b.code_ready;
         vld = dif_b.code_valid; cd = dif_b.code_in;
      end
      if (rst) begin
         prev_line[i] = '0;
         run_len[i]   = 0;
         return;
      end
      chk($sformatf("onehot%0d", i), 32'($countones(ln) <= 1), 32'd1);
      if (ln != 0 && prev_line[i] == 0) begin
         if ((i == 0 && exp_a.size() == 0) || (i == 1 && exp_b.size() == 0)) begin
            chk($sformatf("unexpected_strobe%0d", i), 32'(ln), 32'd0);
         end else begin
            e = (i == 0) ? exp_a.pop_front() : exp_b.pop_front();
            chk($sformatf("line%0d", i), 32'(ln), 32'(e));
         end
         run_len[i] = 1;
      end else if (ln != 0) begin
         chk($sformatf("hold%0d", i), 32'(ln), 32'(prev_line[i]));
         run_len[i]++;
      end else if (prev_line[i] != 0) begin
         chk($sformatf("width%0d", i), 32'(run_len[i]), 32'(plen[i]));
         chk($sformatf("done_end%0d", i), 32'(dn), 32'd1);
      end else begin
         chk($sformatf("done_idle%0d", i), 32'(dn), 32'd0);
      end
      prev_line[i] = ln;
      // Handshake seen now completes on the next rising edge.
      if (vld && rdy) begin
         acc_cnt[i]++;
         acc_cyc[i] = cyc;
         if (!(ZERO_EN && cd == 3'b000)) begin
            if (i == 0) exp_a.push_back(exp_line(cd));
            else        exp_b.push_back(exp_line(cd));
         end
         $display("accept dut%0d code=%b t=%0t", i, cd, $time);
      end
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   // Drive a code (call at posedge+1); returns at accept edge +1.
   task automatic send(input int i, input logic [2:0] c, input bit hold);
      int start;
      bit got;
      start = acc_cnt[i];
      got   = 1'b0;
      if (i == 0) begin dif_a.code_in = c; dif_a.code_valid = 1'b1; end
      else        begin dif_b.code_in = c; dif_b.code_valid = 1'b1; end
      for (int k = 0; k < 60 && !got; k++) begin
         @(posedge clk);
         if (acc_cnt[i] != start) got = 1'b1;
      end
      if (!got) chk($sformatf("accept_timeout%0d", i), 32'd0, 32'd1);
      #1;
      if (!hold) begin
         if (i == 0) dif_a.code_valid = 1'b0;
         else        dif_b.code_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input int i);
      bit idle;
      idle = 1'b0;
      for (int k = 0; k < 100 && !idle; k++) begin
         @(posedge clk);
         #1;
         if (i == 0) idle = (dif_a.line_out == 0) && !dif_a.busy && exp_a.size() == 0;
         else        idle = (dif_b.line_out == 0) && !dif_b.busy && exp_b.size() == 0;
      end
      if (!idle) chk($sformatf("idle_timeout%0d", i), 32'd0, 32'd1);
   endtask

   initial begin
      logic [2:0] sweep [8];
      int last_cyc;
      sweep = '{3'b111, 3'b110, 3'b101, 3'b100, 3'b010, 3'b001, 3'b011, 3'b000};

      dif_a.code_in = '0; dif_a.code_valid = 1'b0;
      dif_b.code_in = '0; dif_b.code_valid = 1'b0;

      // Reset held 3 cycles
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("rst_ready_a", 32'(dif_a.code_ready), 32'd0);
         chk("rst_ready_b", 32'(dif_b.code_ready), 32'd0);
      end
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 32'(dif_a.code_ready), 32'd1);
      chk("post_rst_line",  32'(dif_a.line_out),   32'd0);
      chk("post_rst_busy",  32'(dif_a.busy),       32'd0);
      chk("post_rst_done",  32'(dif_a.done),       32'd0);

      // Single 111 strobe on default parameters
      @(posedge clk); #1;
      send(0, 3'b111, 1'b0);
      chk("first_active_line", 32'(dif_a.line_out), 32'h80);
      repeat (4) @(posedge clk);
      #1;
      chk("gap_ready", 32'(dif_a.code_ready), 32'd0);
      chk("gap_busy",  32'(dif_a.busy),       32'd1);
      chk("gap_done",  32'(dif_a.done),       32'd1);
      @(posedge clk); #1;
      chk("gap_end_ready", 32'(dif_a.code_ready), 32'd1);
      chk("gap_end_done",  32'(dif_a.done),       32'd0);

      // Sweep all codes on dut_b, valid held high, 2-cycle spacing
      @(posedge clk); #1;
      for (int k = 0; k < 8; k++) begin
         send(1, sweep[k], k != 7);
         if (k > 0) chk("sweep_spacing", 32'(acc_cyc[1] - last_cyc), 32'd2);
         last_cyc = acc_cyc[1];
      end
      wait_idle(1);

      // Valid held high, code changes during ACTIVE of 110
      wait_idle(0);
      send(0, 3'b110, 1'b1);
      last_cyc = acc_cyc[0];
      dif_a.code_in = 3'b001;
      @(posedge clk); #1;
      chk("ignore_line", 32'(dif_a.line_out), 32'h40);
      send(0, 3'b001, 1'b0);
      chk("hold_spacing", 32'(acc_cyc[0] - last_cyc), 32'd6);
      chk("hold_line2",   32'(dif_a.line_out),     32'h04);

      // Reset in the 2nd ACTIVE cycle of 010
      wait_idle(0);
      send(0, 3'b010, 1'b0);
      @(posedge clk); #1;
      chk("pre_rst_line", 32'(dif_a.line_out), 32'h08);
      rst = 1'b1;
      #1;
      chk("async_rst_line",  32'(dif_a.line_out),   32'd0);
      chk("async_rst_busy",  32'(dif_a.busy),       32'd0);
      chk("async_rst_ready", 32'(dif_a.code_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_no_done", 32'(dif_a.done), 32'd0);
      @(posedge clk); #1;
      send(0, 3'b100, 1'b0);
      chk("after_rst_line", 32'(dif_a.line_out), 32'h10);

      // Code 000 on default parameters
      wait_idle(0);
      last_cyc = acc_cnt[0];
      send(0, 3'b000, 1'b0);
      chk("zero_handshake", 32'(acc_cnt[0] - last_cyc), 32'd1);
      chk("zero_line", 32'(dif_a.line_out), ZERO_EN ? 32'd0 : 32'h01);
      wait_idle(0);

      repeat (3) @(posedge clk);
      chk("sb_empty_a", 32'(exp_a.size()), 32'd0);
      chk("sb_empty_b", 32'(exp_b.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/code_pulse_decoder.md
Name: code_pulse_decoder

Overview:
- Inverse of the team's 8-line priority code: takes a 3-bit line code over a valid/ready handshake and drives the matching one of eight output lines.
- The selected line is held as a timed strobe of PULSE_LEN cycles, then a GAP_LEN-cycle recovery gap follows.
- Sits on the command side of the arbiter path and re-expands encoded grants into per-line enables.

Parameters:
- PULSE_LEN, 4, strobe length in cycles; legal 1..255.
- GAP_LEN, 1, idle cycles after a strobe before the next code is accepted; legal 0..255.
- CNT_W, 8, width of the internal cycle counter; must hold max(PULSE_LEN, GAP_LEN).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- code_in  in  3  line code, sampled only on handshake.
- code_valid  in  1  code_in is valid.
- code_ready  out  1  block can accept a code.
- line_out  out  8  one-hot strobe; all zero when not strobing.
- busy  out  1  high in ACTIVE or GAP.
- done  out  1  single-cycle pulse when a strobe ends.

Behaviour:
- Decode table (fixed):
  - 111->line 7, 110->6, 101->5, 100->4.
  - 010->3, 001->2, 011->1, 000->0.
- Reset values (async, immediate):
  - state=IDLE, line_out=0, done=0, busy=0, counter=0.
  - code_ready forced 0 while rst high.
- States: IDLE, ACTIVE, GAP. code_ready = (state==IDLE) && !rst, combinational from state.
- IDLE: on a clk edge with code_valid && code_ready:
  - capture code_in.
  - next cycle: line_out = decoded one-hot, state=ACTIVE, counter=PULSE_LEN-1.
  - Without valid, stay in IDLE with line_out=0.
- ACTIVE: line_out holds the captured value; code_in and code_valid are ignored. Counter decrements each cycle. When counter==0 at the edge:
  - line_out=0.
  - done=1 for exactly one cycle.
  - GAP_LEN==0: go to IDLE.
  - Otherwise: go to GAP with counter=GAP_LEN-1.
- GAP: line_out=0, counter decrements; at 0 go to IDLE.
- Timing:
  - Latency from accept edge to line_out asserted: 1 cycle.
  - Strobe width: exactly PULSE_LEN cycles.
  - Minimum accept-to-accept spacing: PULSE_LEN+GAP_LEN+1 cycles.
- done is asserted in the first non-ACTIVE cycle and coincides with code_ready when GAP_LEN==0.
- line_out and done are registered outputs. line_out never has more than one bit set.
- Reset mid-strobe: line_out drops to 0 asynchronously. The captured code is discarded and no done is issued.
- code_valid held high continuously: codes are accepted at the maximum rate, one per IDLE visit.
- PULSE_LEN=1: single-cycle strobe; done follows on the next cycle.

Optional Feature:
- Macro: DEC_ZERO_IDLE_EN.
- Defined:
  - Code 000 means "no request"; it is still accepted, so the handshake completes.
  - FSM goes straight from IDLE to GAP (or stays in IDLE if GAP_LEN==0).
  - line_out stays 0 and done is not pulsed.
- Undefined: 000 decodes to line 0 and follows the normal ACTIVE path.

Decomposition:
- Shared package (team priority-code package):
  - 3-bit code typedef and 8-bit one-hot line typedef.
  - State enum {IDLE, ACTIVE, GAP}.
  - Decode function implementing the fixed table.
  - Reused by the existing encoder's testbench for round-trip checks.
- One natural sub-module: code_onehot_lut, a combinational 3->8 table instantiated once on the captured code. FSM and counter stay in the top.

Test Plan:
- Reset then idle (rst high 3 cycles, release) -> code_ready=0 during reset then 1; line_out=8'h00, busy=0, done=0.
- Default params, send 3'b111 -> line_out=8'h80 for exactly 4 cycles starting 1 cycle after accept; done pulses once; code_ready returns 1 after one gap cycle.
- Sweep all 8 codes (PULSE_LEN=1, GAP_LEN=0) -> line_out sequence 80,40,20,10,08,04,02,01 for codes 111,110,101,100,010,001,011,000; spacing 2 cycles.
- Hold code_valid high and change code_in to 3'b001 during ACTIVE of a 3'b110 strobe -> line_out stays 8'h40, no accept; 001 is accepted only once code_ready=1, giving 8'h04.
- Assert rst in the 2nd ACTIVE cycle of 3'b010 -> line_out=0 immediately, no done; after release a new 3'b100 gives 8'h10.
- Send 3'b000 with DEC_ZERO_IDLE_EN defined vs undefined -> defined: handshake completes, line_out stays 0, no done. Undefined: line_out=8'h01 for PULSE_LEN cycles and done pulses.
